// File: rtl/seven_segment_scanner.sv
// Purpose : time-multiplexes four double-buffered hex digits onto a common-anode display.
// Latency : DataOut/Anodes are combinational from state; a load appears at the next frame start.
// Backpress: none; LoadStrobe is always accepted, and a later strobe replaces any pending value.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   DigitsIn[15:0]      four nibbles, [3:0] = digit 0 (rightmost)
//   LoadStrobe          captures DigitsIn into the pending buffer
//   DataOut[3:0]        nibble of the active digit (feeds the segment decoder)
//   Anodes[3:0]         active-low anode enables, bit i = digit i
//   DigitIndex[1:0]     current digit slot
//   FrameStart          one-cycle pulse on the first cycle of slot 0
//   UpdatePending       a captured value is waiting for the next frame boundary
//
// Optional: define LEADING_ZERO_BLANK_EN to leave leading-zero digits (never digit 0) dark.

module seven_segment_scanner #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 2000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] DigitsIn,
    input  logic        LoadStrobe,
    output logic [3:0]  DataOut,
    output logic [3:0]  Anodes,
    output logic [1:0]  DigitIndex,
    output logic        FrameStart,
    output logic        UpdatePending
);

    localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] TERM_CNT = CW'(TICKS_PER_DIGIT - 1);

    logic [CW-1:0] r_count;
    logic [1:0]    r_digit_idx;
    logic [15:0]   r_display;
    logic [15:0]   r_pending;
    logic          r_upd_pending;
    logic          r_frame_start;

    logic          w_terminal;
    logic          w_boundary;
    logic          w_blank;
    logic          w_lz_blank;

    assign w_terminal = (r_count == TERM_CNT);
    // Last cycle of slot 3: the only point where the display buffer may change.
    assign w_boundary = w_terminal && (r_digit_idx == 2'd3);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count       <= '0;
            r_digit_idx   <= 2'd0;
            r_display     <= 16'h0000;
            r_pending     <= 16'h0000;
            r_upd_pending <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_terminal) begin
                r_count     <= '0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_count <= r_count + CW'(1);
            end

            r_frame_start <= w_boundary;

            // The display takes the value pending before this edge, so a strobe
            // landing on the boundary itself waits for the following frame.
            if (w_boundary && r_upd_pending) begin
                r_display <= r_pending;
            end

            if (LoadStrobe) begin
                r_pending     <= DigitsIn;
                r_upd_pending <= 1'b1;
            end else if (w_boundary) begin
                r_upd_pending <= 1'b0;
            end
        end
    end

    generate
        if (BLANK_TICKS > 0) begin : g_blank
            localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_TICKS);
            assign w_blank = (r_count < BLANK_CNT);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_digit_idx)
            2'd3:    w_lz_blank = (r_display[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_display[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_display[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        DataOut = r_display[{r_digit_idx, 2'b00} +: 4];
        Anodes  = 4'b1111;
        if (!w_blank && !w_lz_blank) begin
            Anodes = ~(4'b0001 << r_digit_idx);
        end
    end

    assign DigitIndex    = r_digit_idx;
    assign FrameStart    = r_frame_start;
    assign UpdatePending = r_upd_pending;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Purpose : scoreboard bench for seven_segment_scanner with a cycle-count reference model.
// Latency : expected outputs are queued one edge ahead and checked 1 ns after each edge.
// Backpress: not applicable; stimulus runs every cycle.

module tb_seven_segment_scanner;

    localparam int TPD   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * TPD;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic        load_stb;
    logic [3:0]  data_out;
    logic [3:0]  anodes;
    logic [1:0]  digit_idx;
    logic        frame_start;
    logic        upd_pending;

    seven_segment_scanner #(
        .TICKS_PER_DIGIT(TPD),
        .BLANK_TICKS    (BLANK)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .DigitsIn     (digits_in),
        .LoadStrobe   (load_stb),
        .DataOut      (data_out),
        .Anodes       (anodes),
        .DigitIndex   (digit_idx),
        .FrameStart   (frame_start),
        .UpdatePending(upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fs;
        logic       upd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    // Reference model: time since reset plus the two buffers and the flag.
    int unsigned m_cyc;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_upd;
    logic        m_fs;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   idx;
        int   cnt;
        logic lzb;
        logic [3:0] one;
        one = 4'b0001;
        idx = int'((m_cyc / TPD) % 4);
        cnt = int'(m_cyc % TPD);
`ifdef LEADING_ZERO_BLANK_EN
        lzb = (idx != 0) && ((m_disp >> (4 * idx)) == 16'h0000);
`else
        lzb = 1'b0;
`endif
        e.data = 4'((m_disp >> (4 * idx)) & 16'h000F);
        e.an   = 4'b1111;
        if (cnt >= BLANK && !lzb) e.an = ~(one << idx);
        e.idx  = 2'(idx);
        e.fs   = m_fs;
        e.upd  = m_upd;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT should show after the edge.
    task automatic step(input logic r, input logic ld, input logic [15:0] din);
        logic boundary;
        @(negedge clk);
        rst       = r;
        load_stb  = ld;
        digits_in = din;
        if (r) begin
            m_cyc  = 0;
            m_disp = 16'h0;
            m_pend = 16'h0;
            m_upd  = 1'b0;
            m_fs   = 1'b0;
        end else begin
            boundary = ((m_cyc % FRAME) == FRAME - 1);
            m_fs = boundary;
            if (boundary && m_upd) m_disp = m_pend;
            if (ld) begin
                m_pend = din;
                m_upd  = 1'b1;
            end else if (boundary) begin
                m_upd = 1'b0;
            end
            m_cyc++;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    // Idle until the next driven cycle is at the given position within the frame.
    task automatic run_to(input int phase);
        while ((m_cyc % FRAME) != phase) step(1'b0, 1'b0, 16'h0);
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("DataOut",       int'(data_out),    int'(e.data));
            chk("Anodes",        int'(anodes),      int'(e.an));
            chk("DigitIndex",    int'(digit_idx),   int'(e.idx));
            chk("FrameStart",    int'(frame_start), int'(e.fs));
            chk("UpdatePending", int'(upd_pending), int'(e.upd));
            chk("OneAnodeMax",   int'($countones(~anodes) <= 1), 1);
        end
    end

    initial begin
        int wait_cnt;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        load_stb  = 1'b0;
        digits_in = 16'h0;
        m_cyc  = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_upd  = 1'b0;
        m_fs   = 1'b0;

        // Reset, then one idle frame plus the first cycle of the next.
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        idle(FRAME + 1);

        // Strobe at frame cycle 5, then watch the transfer frame.
        run_to(5);
        step(1'b0, 1'b1, 16'h1A2F);
        idle(2 * FRAME);

        // Two strobes in one frame: last value wins.
        run_to(2);
        step(1'b0, 1'b1, 16'h1111);
        run_to(9);
        step(1'b0, 1'b1, 16'h2222);
        idle(2 * FRAME);

        // Strobe on the boundary cycle with another value already pending.
        run_to(3);
        step(1'b0, 1'b1, 16'h4444);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h3333);
        idle(2 * FRAME);

        // Reset mid-frame while slot 2 shows part of 0xBEEF.
        step(1'b0, 1'b1, 16'hBEEF);
        run_to(0);
        run_to(2 * TPD + 1);
        step(1'b1, 1'b0, 16'h0);
        idle(3);

        // Leading-zero pattern.
        step(1'b0, 1'b1, 16'h0050);
        run_to(0);
        idle(FRAME + 1);

        // Random strobes, data and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            logic        ld;
            logic        r;
            d  = 16'($urandom);
            if (($urandom % 3) == 0) d = d & 16'h00FF;
            ld = (($urandom % 8) == 0);
            r  = (($urandom % 250) == 0);
            step(r, ld, d);
        end

        // Let the monitor drain, with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("ScoreboardDrained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
